framebuffer_zoom_writer: RTL and testbench

- Write-side counterpart of the VGA framebuffer scan-out path.
- Fills the 320x240, 8-bit framebuffer RAM through its write port, one pixel per clock.
- Pixels come from a source image memory. Three modes: 1:1 copy, 2x zoom-in (centre crop, nearest-neighbour) and 2x zoom-out (decimation, centred, zero border).
- Sits between the source image ROM/RAM and the framebuffer RAM that the display path reads.

---
 rtl/framebuffer_zoom_writer_pkg.sv | 21 ++
 rtl/framebuffer_zoom_writer_if.sv | 28 ++
 rtl/framebuffer_zoom_writer_zoom_addr_gen.sv | 32 +++
 rtl/framebuffer_zoom_writer.sv | 113 +++++++++++
 tb/tb_framebuffer_zoom_writer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_zoom_writer_pkg.sv
// framebuffer_zoom_writer_pkg: shared defaults, mode encodings and FSM states for the framebuffer writer
package framebuffer_zoom_writer_pkg;
    localparam int DEF_IMG_W  = 320;
    localparam int DEF_IMG_H  = 240;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_COPY     = 2'b00,
        MODE_ZOOM_IN  = 2'b01,
        MODE_ZOOM_OUT = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/framebuffer_zoom_writer_if.sv
// framebuffer_zoom_writer_if: control handshake plus source-read and framebuffer-write buses
interface framebuffer_zoom_writer_if
    import framebuffer_zoom_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start;
    logic [1:0]        mode;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] src_addr;
    logic              src_rden;
    logic [DATA_W-1:0] src_q;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_wren;

    modport master (
        input  start, mode, src_q,
        output busy, done, src_addr, src_rden, fb_addr, fb_data, fb_wren
    );

    modport slave (
        output start, mode, src_q,
        input  busy, done, src_addr, src_rden, fb_addr, fb_data, fb_wren
    );
endinterface

// File: rtl/framebuffer_zoom_writer_zoom_addr_gen.sv
// framebuffer_zoom_writer_zoom_addr_gen: maps output pixel (x,y) to a source address or a zero-fill slot
module framebuffer_zoom_writer_zoom_addr_gen
    import framebuffer_zoom_writer_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  mode_e                      mode,
    input  logic [$clog2(IMG_W)-1:0]   x,
    input  logic [$clog2(IMG_H)-1:0]   y,
    output logic                       fill,
    output logic [ADDR_W-1:0]          addr
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);
    localparam logic [X_W-1:0] X_LO = X_W'(IMG_W / 4);
    localparam logic [X_W-1:0] X_HI = X_W'(3 * IMG_W / 4);
    localparam logic [Y_W-1:0] Y_LO = Y_W'(IMG_H / 4);
    localparam logic [Y_W-1:0] Y_HI = Y_W'(3 * IMG_H / 4);

    logic [X_W-1:0] sx;
    logic [Y_W-1:0] sy;

    // outside the zoom-out window the subtraction wraps, but those slots are fill and never read
    always_comb begin
        sx   = mode == MODE_ZOOM_IN ? (x >> 1) + X_LO : mode == MODE_ZOOM_OUT ? (x - X_LO) << 1 : x;
        sy   = mode == MODE_ZOOM_IN ? (y >> 1) + Y_LO : mode == MODE_ZOOM_OUT ? (y - Y_LO) << 1 : y;
        fill = mode == MODE_ZOOM_OUT && !(x >= X_LO && x < X_HI && y >= Y_LO && y < Y_HI);
        addr = ADDR_W'(sy) * ADDR_W'(IMG_W) + ADDR_W'(sx);
    end
endmodule

// File: rtl/framebuffer_zoom_writer.sv
// framebuffer_zoom_writer: fills the framebuffer one pixel per clock from a source image,
// as a 1:1 copy, a centred 2x zoom-in, or a centred 2x zoom-out with zero border
module framebuffer_zoom_writer
    import framebuffer_zoom_writer_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SRC_LAT = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    framebuffer_zoom_writer_if.master bus
);
    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H);

    typedef struct packed {
        logic              valid;
        logic              fill;
        logic [ADDR_W-1:0] addr;
    } slot_t;

    state_e            state;
    mode_e             mode_q;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] pix;
    logic [2:0]        wait_cnt;
    logic              busy_q;
    logic              done_q;
    slot_t             pipe [SRC_LAT];
    logic              run;
    logic              last;
    logic              fill;
    logic [ADDR_W-1:0] map_addr;

    assign run  = state == ST_RUN;
    assign last = x == X_W'(IMG_W - 1) && y == Y_W'(IMG_H - 1);

    framebuffer_zoom_writer_zoom_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .mode(mode_q),
        .x   (x),
        .y   (y),
        .fill(fill),
        .addr(map_addr)
    );

    assign bus.src_rden = run && !fill;
    assign bus.src_addr = bus.src_rden ? map_addr : '0;
    assign bus.fb_wren  = pipe[SRC_LAT-1].valid;
    assign bus.fb_addr  = pipe[SRC_LAT-1].addr;
    assign bus.fb_data  = pipe[SRC_LAT-1].valid && !pipe[SRC_LAT-1].fill ? bus.src_q : '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_COPY;
            x        <= '0;
            y        <= '0;
            pix      <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (bus.start) begin
                    state  <= ST_RUN;
                    mode_q <= mode_e'(bus.mode);
                    x      <= '0;
                    y      <= '0;
                    pix    <= '0;
                    busy_q <= 1'b1;
                end
                ST_RUN: begin
                    pix      <= pix + 1'b1;
                    x        <= x == X_W'(IMG_W - 1) ? '0 : x + 1'b1;
                    y        <= x == X_W'(IMG_W - 1) && !last ? y + 1'b1 : last ? '0 : y;
                    wait_cnt <= '0;
                    if (last) state <= ST_DRAIN;
                end
                // let the reads still in flight land before signalling completion
                ST_DRAIN: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == 3'(SRC_LAT - 1)) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // the slot tag travels alongside the source read so data and address meet at the write port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SRC_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{valid: run, fill: run && fill, addr: run ? pix : '0};
            for (int k = 1; k < SRC_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end
endmodule

// File: tb/tb_framebuffer_zoom_writer.sv
// tb_framebuffer_zoom_writer: random source images checked against a pixel-mapping reference model,
// on a reduced 40x24 frame so every mode runs to completion several times
module tb_framebuffer_zoom_writer;
    localparam int W       = 40;
    localparam int H       = 24;
    localparam int N       = W * H;
    localparam int SRC_LAT = 2;
    localparam int AW      = 17;
    localparam int DW      = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, first_wr = -1, last_wr = -1;
    int   done_cyc = 0, bad_addr = 0, t0 = 0;

    logic [DW-1:0] src [N];
    logic [DW-1:0] fb [N];
    logic [DW-1:0] rd_pipe [SRC_LAT];

    framebuffer_zoom_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    framebuffer_zoom_writer #(
        .IMG_W  (W),
        .IMG_H  (H),
        .ADDR_W (AW),
        .DATA_W (DW),
        .SRC_LAT(SRC_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // source memory: synchronous read with SRC_LAT clocks of latency
    always @(posedge clock) begin
        rd_pipe[0] <= bus.src_rden ? (int'(bus.src_addr) < N ? src[bus.src_addr] : 8'h00) : 'x;
        for (int k = 1; k < SRC_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.src_q = rd_pipe[SRC_LAT-1];

    // framebuffer memory and activity counters, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.fb_wren) begin
            if (int'(bus.fb_addr) < N) fb[bus.fb_addr] = bus.fb_data;
            else bad_addr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (bus.src_rden) rd_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic int px(input int x, input int y);
        return y * W + x;
    endfunction

    function automatic logic [DW-1:0] ref_pix(input logic [1:0] m, input int x, input int y);
        if (m == 2'b01) return src[px(x / 2 + W / 4, y / 2 + H / 4)];
        if (m == 2'b10)
            return (x >= W / 4 && x < 3 * W / 4 && y >= H / 4 && y < 3 * H / 4) ?
                   src[px(2 * (x - W / 4), 2 * (y - H / 4))] : '0;
        return src[px(x, y)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic prep();
        for (int i = 0; i < N; i++) begin
            src[i] = 8'($urandom_range(1, 255));
            fb[i]  = 'x;
        end
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1; bad_addr = 0;
    endtask

    task automatic start_frame(input logic [1:0] m);
        @(negedge clock);
        bus.start = 1'b1;
        bus.mode  = m;
        t0        = cyc;
        @(negedge clock);
        bus.start = 1'b0;
        bus.mode  = 2'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < N + SRC_LAT + 20) begin
            @(negedge clock);
            n++;
        end
        chk("done_within_bound", done_cnt != 0, 1);
        repeat (4) @(negedge clock);
    endtask

    task automatic run_frame(input logic [1:0] m);
        prep();
        start_frame(m);
        wait_done();
    endtask

    task automatic check_frame(input string tag, input logic [1:0] m);
        int bad = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (fb[px(x, y)] !== ref_pix(m, x, y)) bad++;
        chk({tag, "_pixels"}, bad, 0);
        chk({tag, "_writes"}, wr_cnt, N);
        chk({tag, "_reads"}, rd_cnt, m == 2'b10 ? N / 4 : N);
        chk({tag, "_gapless"}, last_wr - first_wr + 1, N);
        chk({tag, "_first_lat"}, first_wr - t0, SRC_LAT + 1);
        chk({tag, "_total"}, done_cyc - t0 + 1, N + SRC_LAT + 2);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_bad_addr"}, bad_addr, 0);
    endtask

    initial begin
        int n;
        int snap;
        logic [1:0] m;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_src_rden", bus.src_rden, 0);
        chk("rst_fb_wren", bus.fb_wren, 0);
        chk("rst_src_addr", bus.src_addr, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_frame(2'b00);
        check_frame("copy", 2'b00);

        run_frame(2'b01);
        check_frame("zoom_in", 2'b01);
        chk("zin_00", fb[px(0, 0)], src[px(W / 4, H / 4)]);
        chk("zin_10", fb[px(1, 0)], src[px(W / 4, H / 4)]);
        chk("zin_01", fb[px(0, 1)], src[px(W / 4, H / 4)]);
        chk("zin_11", fb[px(1, 1)], src[px(W / 4, H / 4)]);
        chk("zin_20", fb[px(2, 0)], src[px(W / 4 + 1, H / 4)]);
        chk("zin_last", fb[px(W - 1, H - 1)], src[px(3 * W / 4 - 1, 3 * H / 4 - 1)]);

        run_frame(2'b10);
        check_frame("zoom_out", 2'b10);
        chk("zout_origin", fb[px(0, 0)], 0);
        chk("zout_left_edge", fb[px(W / 4 - 1, H / 4)], 0);
        chk("zout_win_first", fb[px(W / 4, H / 4)], src[px(0, 0)]);
        chk("zout_win_second", fb[px(W / 4 + 1, H / 4)], src[px(2, 0)]);
        chk("zout_win_last", fb[px(3 * W / 4 - 1, 3 * H / 4 - 1)], src[px(W - 2, H - 2)]);
        chk("zout_right_edge", fb[px(3 * W / 4, 3 * H / 4 - 1)], 0);

        run_frame(2'b11);
        check_frame("reserved_mode", 2'b11);

        prep();
        start_frame(2'b00);
        repeat (N / 2) @(negedge clock);
        bus.start = 1'b1;
        bus.mode  = 2'b01;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        check_frame("busy_start", 2'b00);
        repeat (40) @(negedge clock);
        chk("busy_start_no_refill", wr_cnt, N);
        chk("busy_start_idle", bus.busy, 0);

        prep();
        start_frame(2'b00);
        n = 0;
        while (wr_cnt < 100 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("reset_reached_pixel", wr_cnt >= 100, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_fb_wren", bus.fb_wren, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_src_rden", bus.src_rden, 0);
        snap = wr_cnt;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        repeat (N / 2) @(negedge clock);
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_no_writes", wr_cnt, snap);
        run_frame(2'b00);
        check_frame("copy_after_reset", 2'b00);

        for (int i = 0; i < 3; i++) begin
            m = 2'($urandom_range(0, 3));
            run_frame(m);
            check_frame("random_mode", m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
